// File: rtl/split_join_ctrl.sv
// Single-warp SIMT split/join controller driving an IPDOM stack.
// Optional stack overflow/underflow protection: define SPLIT_JOIN_ERR_EN.
module split_join_ctrl #(
  parameter  int NUM_THREADS = 4,
  parameter  int PC_WIDTH    = 32,
  localparam int ENTRYW      = NUM_THREADS + PC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   split_valid,
  output logic                   split_ready,
  input  logic [NUM_THREADS-1:0] split_taken,
  input  logic [PC_WIDTH-1:0]    split_pc_next,
  input  logic                   join_valid,
  output logic                   join_ready,
  output logic [NUM_THREADS-1:0] tmask,
  output logic                   redirect_valid,
  output logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic                   stk_pair,
  output logic [ENTRYW-1:0]      stk_q1,
  output logic [ENTRYW-1:0]      stk_q2,
  input  logic [ENTRYW-1:0]      stk_d,
  input  logic                   stk_index,
  input  logic                   stk_empty,
  input  logic                   stk_full,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t                 r_state;
  logic [NUM_THREADS-1:0] r_tmask;
  logic                   r_redirect_valid;
  logic [PC_WIDTH-1:0]    r_redirect_pc;

  logic                   w_split_acc;
  logic                   w_join_acc;
  logic                   w_ovf;
  logic                   w_unf;
  logic                   w_divergent;
  logic [NUM_THREADS-1:0] w_taken;
  logic [NUM_THREADS-1:0] w_else;
  logic [NUM_THREADS-1:0] w_pop_mask;
  logic [PC_WIDTH-1:0]    w_pop_pc;

  assign split_ready = (r_state == IDLE);
  assign join_ready  = (r_state == IDLE) & ~split_valid;
  assign w_split_acc = split_valid & split_ready;
  assign w_join_acc  = join_valid & join_ready;

  assign w_taken     = split_taken & r_tmask;
  assign w_else      = ~split_taken & r_tmask;
  assign w_divergent = (|w_taken) & (|w_else);

  assign w_pop_mask  = stk_d[ENTRYW-1 -: NUM_THREADS];
  assign w_pop_pc    = stk_d[PC_WIDTH-1:0];

`ifdef SPLIT_JOIN_ERR_EN
  logic r_err_ovf;
  logic r_err_unf;

  assign w_ovf         = w_split_acc & stk_full;
  assign w_unf         = w_join_acc & stk_empty;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (w_ovf) r_err_ovf <= 1'b1;
      if (w_unf) r_err_unf <= 1'b1;
    end
  end
`else
  logic w_unused_status;

  // Stack status is irrelevant when protection is compiled out.
  assign w_unused_status = stk_full ^ stk_empty;
  assign w_ovf           = 1'b0;
  assign w_unf           = 1'b0;
  assign err_overflow    = 1'b0;
  assign err_underflow   = 1'b0;
`endif

  assign stk_push = w_split_acc & ~w_ovf;
  assign stk_pop  = w_join_acc & ~w_unf;
  assign stk_pair = w_divergent;
  assign stk_q1   = {r_tmask, {PC_WIDTH{1'b0}}};
  assign stk_q2   = {w_else, split_pc_next};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_tmask          <= '1;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_split_acc) begin
            r_state <= SETTLE;
            if (stk_push && w_divergent) r_tmask <= w_taken;
          end else if (w_join_acc) begin
            r_state <= SETTLE;
            if (stk_pop) begin
              r_tmask <= w_pop_mask;
              // index 0 marks a pending else path that fetch must jump to
              if (!stk_index) begin
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= w_pop_pc;
              end
            end
          end
        end
        SETTLE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tmask          = r_tmask;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_split_join_ctrl.sv
// Bench for split_join_ctrl: behavioural IPDOM stack, directed vector table,
// hand-written corner sequences and randomized ops against a reference model.
module tb_split_join_ctrl;

  localparam int NT     = 4;
  localparam int PW     = 32;
  localparam int EW     = NT + PW;
  localparam int DEPTH  = 8;
`ifdef SPLIT_JOIN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          split_valid, split_ready, join_valid, join_ready;
  logic [NT-1:0] split_taken, tmask;
  logic [PW-1:0] split_pc_next, redirect_pc;
  logic          redirect_valid, stk_push, stk_pop, stk_pair;
  logic [EW-1:0] stk_q1, stk_q2, stk_d;
  logic          stk_index, stk_empty, stk_full;
  logic          err_overflow, err_underflow;
  logic          force_full, force_empty;

  always #5 clk = ~clk;

  split_join_ctrl #(.NUM_THREADS(NT), .PC_WIDTH(PW)) dut (
    .clk(clk), .reset(reset),
    .split_valid(split_valid), .split_ready(split_ready),
    .split_taken(split_taken), .split_pc_next(split_pc_next),
    .join_valid(join_valid), .join_ready(join_ready),
    .tmask(tmask), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_pair(stk_pair),
    .stk_q1(stk_q1), .stk_q2(stk_q2), .stk_d(stk_d),
    .stk_index(stk_index), .stk_empty(stk_empty), .stk_full(stk_full),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  // IPDOM stack environment: q1 entries carry index 1, q2 (else) entries index 0.
  logic [EW-1:0] smem [DEPTH];
  logic          sflag[DEPTH];
  int            sp = 0;

  always @(posedge clk) begin
    if (reset) sp <= 0;
    else if (stk_push) begin
      if (sp < DEPTH) begin smem[sp] <= stk_q1; sflag[sp] <= 1'b1; end
      if (stk_pair && sp + 1 < DEPTH) begin smem[sp+1] <= stk_q2; sflag[sp+1] <= 1'b0; end
      sp <= sp + (stk_pair ? 2 : 1);
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end

  always_comb begin
    stk_d     = '0;
    stk_index = 1'b1;
    if (sp > 0) begin
      stk_d     = smem[sp-1];
      stk_index = sflag[sp-1];
    end
    stk_empty = (sp == 0) | force_empty;
    stk_full  = (sp >= DEPTH - 1) | force_full;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic          sv;
    logic          jv;
    logic [NT-1:0] taken;
    logic [PW-1:0] pcn;
    logic          e_push;
    logic          e_pair;
    logic          e_pop;
    logic [EW-1:0] e_q1;
    logic [EW-1:0] e_q2;
    logic [NT-1:0] e_tmask;
    logic          e_rv;
    logic [PW-1:0] e_rpc;
  } vec_t;

  typedef struct {
    logic [NT-1:0] mask;
    logic [PW-1:0] pc;
    bit            is_else;
  } frame_t;

  vec_t          vecs[13];
  frame_t        rq[$];
  frame_t        fr;
  logic [NT-1:0] rm, rt, tk, el;
  logic [PW-1:0] rpc, rp;
  logic          erv;
  bit            do_split;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'b0011, 32'h100, 1'b1, 1'b1, 1'b0, {4'hF, 32'h0}, {4'hC, 32'h100}, 4'h3, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b1, '0, '0, 4'hC, 1'b1, 32'h100};
    vecs[2]  = '{1'b0, 1'b1, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b1, '0, '0, 4'hF, 1'b0, 32'h100};
    vecs[3]  = '{1'b1, 1'b0, 4'b1111, 32'h40,  1'b1, 1'b0, 1'b0, {4'hF, 32'h0}, '0, 4'hF, 1'b0, 32'h100};
    vecs[4]  = '{1'b0, 1'b1, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b1, '0, '0, 4'hF, 1'b0, 32'h100};
    vecs[5]  = '{1'b1, 1'b0, 4'b0000, 32'h44,  1'b1, 1'b0, 1'b0, {4'hF, 32'h0}, '0, 4'hF, 1'b0, 32'h100};
    vecs[6]  = '{1'b0, 1'b1, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b1, '0, '0, 4'hF, 1'b0, 32'h100};
    vecs[7]  = '{1'b1, 1'b0, 4'b0101, 32'h200, 1'b1, 1'b1, 1'b0, {4'hF, 32'h0}, {4'hA, 32'h200}, 4'h5, 1'b0, 32'h100};
    vecs[8]  = '{1'b1, 1'b0, 4'b0011, 32'h300, 1'b1, 1'b1, 1'b0, {4'h5, 32'h0}, {4'h4, 32'h300}, 4'h1, 1'b0, 32'h100};
    vecs[9]  = '{1'b0, 1'b1, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b1, '0, '0, 4'h4, 1'b1, 32'h300};
    vecs[10] = '{1'b0, 1'b1, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b1, '0, '0, 4'h5, 1'b0, 32'h300};
    vecs[11] = '{1'b0, 1'b1, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b1, '0, '0, 4'hA, 1'b1, 32'h200};
    vecs[12] = '{1'b0, 1'b1, 4'b0000, 32'h0,   1'b0, 1'b0, 1'b1, '0, '0, 4'hF, 1'b0, 32'h200};

    reset = 1'b1; split_valid = 1'b0; join_valid = 1'b0;
    split_taken = '0; split_pc_next = '0; force_full = 1'b0; force_empty = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tmask", 64'(tmask), 64'hF);
    chk("rst_split_ready", 64'(split_ready), 64'h1);
    chk("rst_join_ready", 64'(join_ready), 64'h1);
    chk("rst_redirect_valid", 64'(redirect_valid), 64'h0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'h0);
    chk("rst_err_overflow", 64'(err_overflow), 64'h0);
    chk("rst_err_underflow", 64'(err_underflow), 64'h0);
    cyc();

    // Directed vector table: each entry is one accepted op plus its settle cycle.
    for (int i = 0; i < 13; i++) begin
      split_valid = vecs[i].sv; join_valid = vecs[i].jv;
      split_taken = vecs[i].taken; split_pc_next = vecs[i].pcn;
      @(negedge clk);
      chk($sformatf("v%0d_push", i), 64'(stk_push), 64'(vecs[i].e_push));
      chk($sformatf("v%0d_pop", i), 64'(stk_pop), 64'(vecs[i].e_pop));
      if (vecs[i].e_push) begin
        chk($sformatf("v%0d_pair", i), 64'(stk_pair), 64'(vecs[i].e_pair));
        chk($sformatf("v%0d_q1", i), 64'(stk_q1), 64'(vecs[i].e_q1));
        if (vecs[i].e_pair) chk($sformatf("v%0d_q2", i), 64'(stk_q2), 64'(vecs[i].e_q2));
      end
      cyc();
      split_valid = 1'b0; join_valid = 1'b0;
      chk($sformatf("v%0d_tmask", i), 64'(tmask), 64'(vecs[i].e_tmask));
      chk($sformatf("v%0d_rv", i), 64'(redirect_valid), 64'(vecs[i].e_rv));
      chk($sformatf("v%0d_rpc", i), 64'(redirect_pc), 64'(vecs[i].e_rpc));
      chk($sformatf("v%0d_ready_t1", i), 64'({split_ready, join_ready}), 64'h0);
      cyc();
      chk($sformatf("v%0d_ready_t2", i), 64'({split_ready, join_ready}), 64'h3);
      chk($sformatf("v%0d_rv_drop", i), 64'(redirect_valid), 64'h0);
    end
    chk("stack_empty_after_vectors", 64'(stk_empty), 64'h1);

    // Simultaneous split and join: split wins, join taken at T+2.
    split_valid = 1'b1; join_valid = 1'b1; split_taken = 4'b0110; split_pc_next = 32'h500;
    @(negedge clk);
    chk("sim_join_ready_T", 64'(join_ready), 64'h0);
    chk("sim_pop_T", 64'(stk_pop), 64'h0);
    chk("sim_push_T", 64'(stk_push), 64'h1);
    cyc();
    split_valid = 1'b0;
    chk("sim_tmask_T1", 64'(tmask), 64'h6);
    @(negedge clk);
    chk("sim_pop_T1", 64'(stk_pop), 64'h0);
    cyc();
    @(negedge clk);
    chk("sim_join_ready_T2", 64'(join_ready), 64'h1);
    chk("sim_pop_T2", 64'(stk_pop), 64'h1);
    cyc();
    join_valid = 1'b0;
    chk("sim_join_tmask", 64'(tmask), 64'h9);
    chk("sim_join_rv", 64'(redirect_valid), 64'h1);
    chk("sim_join_rpc", 64'(redirect_pc), 64'h500);
    cyc();
    join_valid = 1'b1;
    cyc();
    join_valid = 1'b0;
    chk("sim_reconv_tmask", 64'(tmask), 64'hF);
    chk("sim_reconv_rv", 64'(redirect_valid), 64'h0);
    cyc();

    // Reset asserted while in SETTLE.
    split_valid = 1'b1; split_taken = 4'b1010; split_pc_next = 32'h600;
    cyc();
    split_valid = 1'b0; reset = 1'b1;
    chk("mid_tmask_before_reset", 64'(tmask), 64'hA);
    cyc();
    reset = 1'b0;
    chk("mid_rst_tmask", 64'(tmask), 64'hF);
    chk("mid_rst_ready", 64'({split_ready, join_ready}), 64'h3);
    chk("mid_rst_rpc", 64'(redirect_pc), 64'h0);
    chk("mid_rst_rv", 64'(redirect_valid), 64'h0);

    // Overflow / underflow handling.
    force_full = 1'b1; split_valid = 1'b1; split_taken = 4'b0011; split_pc_next = 32'h700;
    @(negedge clk);
    chk("ovf_push", 64'(stk_push), ERR_EN ? 64'h0 : 64'h1);
    cyc();
    split_valid = 1'b0; force_full = 1'b0;
    chk("ovf_tmask", 64'(tmask), ERR_EN ? 64'hF : 64'h3);
    chk("ovf_flag", 64'(err_overflow), ERR_EN ? 64'h1 : 64'h0);
    repeat (10) cyc();
    chk("ovf_flag_sticky", 64'(err_overflow), ERR_EN ? 64'h1 : 64'h0);
    force_empty = 1'b1; join_valid = 1'b1;
    @(negedge clk);
    chk("unf_pop", 64'(stk_pop), ERR_EN ? 64'h0 : 64'h1);
    cyc();
    join_valid = 1'b0; force_empty = 1'b0;
    chk("unf_tmask", 64'(tmask), ERR_EN ? 64'hF : 64'hC);
    chk("unf_rv", 64'(redirect_valid), ERR_EN ? 64'h0 : 64'h1);
    chk("unf_flag", 64'(err_underflow), ERR_EN ? 64'h1 : 64'h0);
    repeat (5) cyc();
    chk("unf_flag_sticky", 64'(err_underflow), ERR_EN ? 64'h1 : 64'h0);

    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;

    // Randomized ops against a frame-queue reference model.
    rm = 4'hF; rpc = '0;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      if (rq.size() == 0) do_split = 1'b1;
      else if (rq.size() > DEPTH - 3) do_split = 1'b0;
      else do_split = bit'($urandom_range(0, 1));
      if (do_split) begin
        rt = NT'($urandom); rp = $urandom;
        split_valid = 1'b1; join_valid = ($urandom_range(0, 3) == 0);
        split_taken = rt; split_pc_next = rp;
        @(negedge clk);
        chk("rnd_split_push", 64'(stk_push), 64'h1);
        chk("rnd_split_nopop", 64'(stk_pop), 64'h0);
        tk = rt & rm; el = ~rt & rm;
        rq.push_back('{rm, '0, 1'b0});
        if (tk != 0 && el != 0) begin
          rq.push_back('{el, rp, 1'b1});
          rm = tk;
        end
        erv = 1'b0;
      end else begin
        join_valid = 1'b1;
        @(negedge clk);
        chk("rnd_join_pop", 64'(stk_pop), 64'h1);
        chk("rnd_join_nopush", 64'(stk_push), 64'h0);
        fr = rq.pop_back();
        rm = fr.mask;
        erv = fr.is_else;
        if (fr.is_else) rpc = fr.pc;
      end
      cyc();
      split_valid = 1'b0; join_valid = 1'b0;
      chk("rnd_tmask", 64'(tmask), 64'(rm));
      chk("rnd_rv", 64'(redirect_valid), 64'(erv));
      chk("rnd_rpc", 64'(redirect_pc), 64'(rpc));
      cyc();
      chk("rnd_rv_pulse", 64'(redirect_valid), 64'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
